// File: rtl/uart_bus_master.sv
// UART-driven bus master: decodes byte commands from an rx stream, issues
// single-cycle 32-bit bus writes/reads, and replies over a tx stream.
// Command frames: W a0 a1 a2 a3 d0 d1 d2 d3 -> ACK, R a0 a1 a2 a3 -> 4 data bytes.
module uart_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1_250_000,
  parameter logic [7:0]  CMD_WRITE      = 8'h57,
  parameter logic [7:0]  CMD_READ       = 8'h52
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] bus_addr_o,
  output logic        bus_write_o,
  output logic        bus_read_o,
  output logic [3:0]  bus_size_o,
  output logic [31:0] bus_dout_o,
  input  logic [31:0] bus_din_i,
  output logic        busy_o
);

  localparam logic [7:0]  ByteAck = 8'h06;
  localparam logic [7:0]  ByteNak = 8'h15;
  localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [2:0] {
    StIdle, StAddr, StWdata, StWrite, StRead, StRcapt, StSend
  } state_e;

  state_e      state_q, state_d;
  logic        is_write_q, is_write_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] reply_q, reply_d;
  logic [2:0]  len_q, len_d;

  // Outputs are registered from the next-state values so they track state_q
  // exactly while carrying no combinational path from the handshake inputs.
  logic        rx_ready_q, rx_ready_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        bus_write_q, bus_write_d;
  logic        bus_read_q, bus_read_d;
  logic [3:0]  bus_size_q, bus_size_d;

  logic rx_acc, tx_acc;
  assign rx_acc = rx_valid_i & rx_ready_q;
  assign tx_acc = tx_valid_q & tx_ready_i;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    reply_d    = reply_q;
    len_d      = len_q;

    unique case (state_q)
      StIdle: begin
        if (rx_acc) begin
          if (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ) begin
            is_write_d = (rx_data_i == CMD_WRITE);
            cnt_d      = 2'd0;
            tmo_d      = 32'd0;
            state_d    = StAddr;
          end else begin
            reply_d = {24'd0, ByteNak};
            len_d   = 3'd1;
            state_d = StSend;
          end
        end
      end
      StAddr, StWdata: begin
        // An accepted byte always beats a coinciding timeout.
        if (rx_acc) begin
          tmo_d = 32'd0;
          cnt_d = cnt_q + 2'd1;
          if (state_q == StAddr) begin
            addr_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
            if (cnt_q == 2'd3) state_d = is_write_q ? StWdata : StRead;
          end else begin
            wdata_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
            if (cnt_q == 2'd3) state_d = StWrite;
          end
        end else if (tmo_q == TmoLast) begin
          reply_d = {24'd0, ByteNak};
          len_d   = 3'd1;
          state_d = StSend;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      StWrite: begin
        reply_d = {24'd0, ByteAck};
        len_d   = 3'd1;
        state_d = StSend;
      end
      StRead: begin
        state_d = StRcapt;
      end
      StRcapt: begin
        // Read data is valid the cycle after the strobe.
        reply_d = bus_din_i;
        len_d   = 3'd4;
        state_d = StSend;
      end
      StSend: begin
        if (tx_acc) begin
          reply_d = {8'd0, reply_q[31:8]};
          len_d   = len_q - 3'd1;
          if (len_q == 3'd1) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    rx_ready_d  = (state_d == StIdle) || (state_d == StAddr) || (state_d == StWdata);
    tx_valid_d  = (state_d == StSend);
    tx_data_d   = (state_d == StSend) ? reply_d[7:0] : 8'd0;
    bus_write_d = (state_d == StWrite);
    bus_read_d  = (state_d == StRead);
    bus_size_d  = (state_d == StWrite) ? 4'b1111 : 4'b0000;
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      is_write_q  <= 1'b0;
      cnt_q       <= 2'd0;
      tmo_q       <= 32'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      reply_q     <= 32'd0;
      len_q       <= 3'd0;
      rx_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      bus_write_q <= 1'b0;
      bus_read_q  <= 1'b0;
      bus_size_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      reply_q     <= reply_d;
      len_q       <= len_d;
      rx_ready_q  <= rx_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      bus_write_q <= bus_write_d;
      bus_read_q  <= bus_read_d;
      bus_size_q  <= bus_size_d;
    end
  end

  assign rx_ready_o  = rx_ready_q;
  assign tx_valid_o  = tx_valid_q;
  assign tx_data_o   = tx_data_q;
  assign bus_write_o = bus_write_q;
  assign bus_read_o  = bus_read_q;
  assign bus_size_o  = bus_size_q;
  assign bus_addr_o  = addr_q;
  assign bus_dout_o  = wdata_q;
  assign busy_o      = (state_q != StIdle);

endmodule
